// File: rtl/ic74xx151_pkg.sv
// Shared types for the scanning 151-style data selector.
package ic74xx151_pkg;

    // Operating mode carried on the 2-bit mode input
    typedef enum logic [1:0] {
        MODE_DIRECT = 2'b00,
        MODE_LATCH  = 2'b01,
        MODE_SCAN   = 2'b10,
        MODE_SWEEP  = 2'b11
    } mode_e;

    // Scan sequencer states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_DWELL   = 2'b01,
        ST_PRESENT = 2'b10
    } state_e;

endpackage

// File: rtl/ic74xx151_chan_sel.sv
// Combinational N:1 selector over a flat bus of DATA_W-bit channels.
module ic74xx151_chan_sel
    import ic74xx151_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int DATA_W = 1
) (
    input  logic [(2**SEL_W)*DATA_W-1:0] i_bus,
    input  logic [SEL_W-1:0]             i_idx,
    output logic [DATA_W-1:0]            o_data
);

    // Pick channel i_idx out of the flat bus
    always_comb begin
        o_data = i_bus[i_idx*DATA_W +: DATA_W];
    end

endmodule

// File: rtl/ic74xx151_scan_mux.sv
// Registered 151-style data selector with direct, latched, auto-scan and
// single-sweep modes; scan samples are offered on a valid/ready stream.
module ic74xx151_scan_mux
    import ic74xx151_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DATA_W  = 1,
    parameter int DWELL_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          EN_Part,
    input  logic [1:0]                    mode,
    input  logic [SEL_W-1:0]              SelectPart,
    input  logic                          sel_load,
    input  logic [(2**SEL_W)*DATA_W-1:0]  Single_Part,
    input  logic [DWELL_W-1:0]            dwell,
    input  logic                          start,
    output logic [DATA_W-1:0]             Y,
    output logic [DATA_W-1:0]             YF,
    output logic [SEL_W-1:0]              ch_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          sweep_done
);

    localparam logic [SEL_W-1:0]   CH_LAST   = {SEL_W{1'b1}};
    localparam logic [SEL_W-1:0]   CH_ONE    = SEL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

    mode_e               w_mode;
    state_e              r_state,    w_state_nxt;
    mode_e               r_run_mode, w_run_mode_nxt;
    logic [DWELL_W-1:0]  r_cnt,      w_cnt_nxt;
    logic [SEL_W-1:0]    r_ch,       w_ch_nxt;
    logic [SEL_W-1:0]    r_latch,    w_latch_nxt;
    logic [DATA_W-1:0]   r_y,        w_y_nxt;
    logic [SEL_W-1:0]    r_ch_out,   w_ch_out_nxt;
    logic                r_valid,    w_valid_nxt;
    logic                r_done,     w_done_nxt;
    logic [SEL_W-1:0]    w_latch_eff;
    logic [SEL_W-1:0]    w_sel_idx;
    logic [DATA_W-1:0]   w_sel_data;

    assign w_mode = mode_e'(mode);

    // Choose the selector index: live select, latch (load bypasses), or scan counter
    always_comb begin
        w_latch_eff = sel_load ? SelectPart : r_latch;
        case (w_mode)
            MODE_DIRECT: w_sel_idx = SelectPart;
            MODE_LATCH:  w_sel_idx = w_latch_eff;
            default:     w_sel_idx = r_ch;
        endcase
    end

    ic74xx151_chan_sel #(
        .SEL_W  (SEL_W),
        .DATA_W (DATA_W)
    ) u_chan_sel (
        .i_bus  (Single_Part),
        .i_idx  (w_sel_idx),
        .o_data (w_sel_data)
    );

    // Next-state and next-output logic for selection and the scan sequencer
    always_comb begin
        w_state_nxt    = r_state;
        w_run_mode_nxt = r_run_mode;
        w_cnt_nxt      = r_cnt;
        w_ch_nxt       = r_ch;
        w_latch_nxt    = r_latch;
        w_y_nxt        = r_y;
        w_ch_out_nxt   = r_ch_out;
        w_valid_nxt    = r_valid;
        w_done_nxt     = 1'b0;

        if (EN_Part) begin
            // Disabled: blank the output and drop any scan, keep the latch
            w_state_nxt = ST_IDLE;
            w_ch_nxt    = '0;
            w_y_nxt     = '0;
            w_valid_nxt = 1'b0;
        end else begin
            if (sel_load) begin
                w_latch_nxt = SelectPart;
            end else begin
                w_latch_nxt = r_latch;
            end

            // Direct and latched modes update Y every cycle
            if (w_mode == MODE_DIRECT || w_mode == MODE_LATCH) begin
                w_y_nxt      = w_sel_data;
                w_ch_out_nxt = w_sel_idx;
            end else begin
                w_y_nxt      = r_y;
                w_ch_out_nxt = r_ch_out;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_mode == MODE_SCAN || (w_mode == MODE_SWEEP && start)) begin
                        w_state_nxt    = ST_DWELL;
                        w_cnt_nxt      = dwell;
                        w_run_mode_nxt = w_mode;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    if (w_mode != r_run_mode) begin
                        w_state_nxt = ST_IDLE;
                        w_ch_nxt    = '0;
                        w_valid_nxt = 1'b0;
                    end else if (r_cnt == '0) begin
                        w_y_nxt      = w_sel_data;
                        w_ch_out_nxt = r_ch;
                        w_valid_nxt  = 1'b1;
                        w_state_nxt  = ST_PRESENT;
                    end else begin
                        w_cnt_nxt = r_cnt - DWELL_ONE;
                    end
                end
                ST_PRESENT: begin
                    if (w_mode != r_run_mode) begin
                        w_state_nxt = ST_IDLE;
                        w_ch_nxt    = '0;
                        w_valid_nxt = 1'b0;
                    end else if (out_ready) begin
                        w_valid_nxt = 1'b0;
                        w_ch_nxt    = r_ch + CH_ONE;
                        if (r_run_mode == MODE_SWEEP && r_ch == CH_LAST) begin
                            w_done_nxt  = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_DWELL;
                            w_cnt_nxt   = dwell;
                        end
                    end else begin
                        // Back-pressure: hold the sample
                        w_state_nxt = ST_PRESENT;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_ch_nxt    = '0;
                    w_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_run_mode <= MODE_DIRECT;
            r_cnt      <= '0;
            r_ch       <= '0;
            r_latch    <= '0;
            r_y        <= '0;
            r_ch_out   <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_mode <= w_run_mode_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ch       <= w_ch_nxt;
            r_latch    <= w_latch_nxt;
            r_y        <= w_y_nxt;
            r_ch_out   <= w_ch_out_nxt;
            r_valid    <= w_valid_nxt;
            r_done     <= w_done_nxt;
        end
    end

    // YF comes from the same register as Y so the pair never skews
    assign Y          = r_y;
    assign YF         = ~r_y;
    assign ch_out     = r_ch_out;
    assign out_valid  = r_valid;
    assign busy       = (r_state != ST_IDLE);
    assign sweep_done = r_done;

endmodule

// File: doc/ic74xx151_scan_mux.md
# ic74xx151_scan_mux

Parametrised sequential successor to the 8-input 151-style data selector. It selects one of 2**SEL_W channels, each DATA_W bits wide, and registers the result onto true and complementary outputs. Beyond the direct-select behaviour it adds three things: a latched-select mode, an auto-scan mode with a programmable dwell time, and a single-sweep mode. The scan modes present each sample on a valid/ready stream. It sits between the board-level input banks and the sampling/logging logic.

## Interface
- SEL_W, 3, select width; channel count N = 2**SEL_W
- DATA_W, 1, bits per channel
- DWELL_W, 8, dwell counter width
- clk  in  1  single clock; all state changes on its rising edge
- rst  in  1  reset, synchronous, active-high
- EN_Part  in  1  active-low enable; high forces outputs inactive and aborts any scan
- mode  in  2  00 direct, 01 latched, 10 auto-scan, 11 single-sweep
- SelectPart  in  SEL_W  channel select (modes 00/01)
- sel_load  in  1  captures SelectPart into the select latch
- Single_Part  in  N*DATA_W  channel data; channel k occupies bits [k*DATA_W +: DATA_W]
- dwell  in  DWELL_W  extra cycles spent on a channel before it is sampled
- start  in  1  single-cycle pulse that launches one sweep (mode 11)
- Y  out  DATA_W  registered selected data
- YF  out  DATA_W  bitwise complement of Y
- ch_out  out  SEL_W  channel index that produced the current Y
- out_valid  out  1  sample available (modes 10/11)
- out_ready  in  1  consumer accepts sample
- busy  out  1  FSM not in IDLE
- sweep_done  out  1  one-cycle pulse after the last sample of a sweep transfers

## Operation
- Reset values:
  - Y=0, YF=all ones, ch_out=0
  - out_valid=0, busy=0, sweep_done=0
  - select latch=0, channel counter=0, FSM=IDLE
- EN_Part=1, highest priority below rst:
  - next cycle Y=0, YF=all ones, out_valid=0
  - FSM returns to IDLE and the channel counter clears to 0
  - the select latch is kept
- Mode 00: Y <= channel[SelectPart]; ch_out <= SelectPart.
- Mode 01: Y <= channel[select latch]; ch_out <= select latch.
  - The latch loads SelectPart when sel_load=1 in any mode.
  - With sel_load=1 the newly loaded value is used in the same cycle's selection.
- Scan FSM states:
  - IDLE: mode 10 enters DWELL unconditionally; mode 11 enters DWELL on start=1; other modes stay in IDLE.
  - DWELL: the counter loads dwell on entry and decrements each cycle. At 0, channel[ch] is captured into Y/ch_out, out_valid is set, and the FSM goes to PRESENT. dwell=0 gives capture one cycle after entry.
  - PRESENT: Y held stable while out_valid=1 and out_ready=0. On out_valid&out_ready:
    - the channel counter increments, wrapping N-1 -> 0;
    - mode 10 returns to DWELL;
    - mode 11 returns to DWELL, except after channel N-1: pulse sweep_done, then IDLE.
- Mode change while busy: FSM aborts to IDLE next cycle, out_valid drops without a transfer, channel counter clears.
- start ignored while busy or when mode≠11.
- YF is always ~Y; both come from one register, so they never skew.

## Timing
- Direct/latched latency: 1 cycle from SelectPart/Single_Part change to Y.
- Scan: sample k becomes valid dwell+1 cycles after DWELL entry.
  - Back-to-back throughput: one sample per dwell+2 cycles with out_ready held high.
- out_valid rises on the capture edge and falls on the cycle after the handshake.
- sweep_done is asserted the cycle after the final handshake, coincident with busy=0.
- rst mid-scan: all outputs return to reset values on the next edge.

## Structure
- Package ic74xx151_pkg:
  - mode enum (MODE_DIRECT, MODE_LATCH, MODE_SCAN, MODE_SWEEP)
  - FSM state enum (ST_IDLE, ST_DWELL, ST_PRESENT)
- One sub-module, ic74xx151_chan_sel: combinational N:1 DATA_W-bit selector over the flat bus, parametrised by SEL_W/DATA_W. Instantiated once, with its index driven from SelectPart, the latch, or the channel counter.

## Test plan
- SEL_W=3, DATA_W=4, Single_Part channel k = k+1, mode 00:
  - SelectPart=5 -> next cycle Y=6, YF=9, ch_out=5.
  - Then EN_Part=1 -> Y=0, YF=15.
- Mode 01, sel_load pulse with SelectPart=2, then SelectPart=7 without load -> Y stays 3, ch_out=2.
- Mode 10, dwell=3, out_ready=1:
  - samples 1,2,…,8,1 appear on ch 0..7,0;
  - out_valid pulses every 5 cycles.
- Mode 10, out_ready held 0 for 10 cycles on ch 4 -> Y=5 and out_valid=1 stable throughout; ch 5 is not sampled until the handshake.
- Mode 11, dwell=0:
  - start pulse -> 8 samples delivered;
  - sweep_done one cycle after the 8th handshake, busy=0;
  - a second start while busy is ignored.
- Scan mid-channel:
  - rst=1 -> all outputs at reset values next cycle;
  - switching mode to 00 -> out_valid=0, busy=0 next cycle.
